// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared constants, state encoding and sizing helper for the nibble-serial subtractor.
// Optional feature macro used by this slice: SUB_OVERFLOW_FLAG_EN.
package sub_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int SLICE_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A single-slice configuration still needs a 1-bit counter to stay legal.
    function automatic int cnt_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

    localparam int CNT_W_DEF = cnt_width(WIDTH_DEF / SLICE_DEF);

endpackage

// File: rtl/nibble_serial_subtractor_if.sv
// Operand/result handshake bundle for the nibble-serial subtractor.
// ovf exists only when SUB_OVERFLOW_FLAG_EN is defined.
interface nibble_serial_subtractor_if #(
    parameter int WIDTH = sub_pkg::WIDTH_DEF
);
    // Handshakes: a transfer happens on a rising clk edge where valid && ready.
    // valid never waits on ready, and a raised valid holds its payload stable
    // until that transfer edge.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bi;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             bo;
`ifdef SUB_OVERFLOW_FLAG_EN
    logic             ovf;
`endif
    logic [1:0]       dbg_state;

    modport master (
        output in_valid, a, b, bi, out_ready,
`ifdef SUB_OVERFLOW_FLAG_EN
        input  ovf,
`endif
        input  in_ready, out_valid, d, bo, dbg_state
    );

    modport slave (
        input  in_valid, a, b, bi, out_ready,
`ifdef SUB_OVERFLOW_FLAG_EN
        output ovf,
`endif
        output in_ready, out_valid, d, bo, dbg_state
    );

endinterface

// File: rtl/nibble_serial_subtractor_slice.sv
// Combinational W-bit borrow subtractor: diff = x - y - bin, built as a
// ripple of full-adder cells computing x + ~y + ~bin.
module nibble_sub_slice #(
    parameter int W = sub_pkg::SLICE_DEF
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         bin,
    output logic [W-1:0] diff,
    output logic         bout
);

    logic [W:0]   c;
    logic [W-1:0] yn;

    assign yn   = ~y;
    assign c[0] = ~bin;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign diff[i]  = x[i] ^ yn[i] ^ c[i];
        assign c[i + 1] = (x[i] & yn[i]) | (c[i] & (x[i] ^ yn[i]));
    end

    // Carry out of the inverted-operand sum is the complement of the borrow.
    assign bout = ~c[W];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle unsigned subtractor d = a - b - bi, one SLICE-bit slice per clock, LSB first.
// Optional signed-overflow output enabled by SUB_OVERFLOW_FLAG_EN.
module nibble_serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF
) (
    input logic                      clk,
    input logic                      rst_n,
    nibble_serial_subtractor_if.slave bus
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = cnt_width(NSLICE);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] BUSY = ST_BUSY;
    localparam logic [1:0] DONE = ST_DONE;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bo_q, bo_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
`ifdef SUB_OVERFLOW_FLAG_EN
    logic             ovf_q, ovf_d;
`endif

    logic [SLICE-1:0] slice_x, slice_y, slice_diff;
    logic             slice_bout;
    logic             last_slice;
    int               slice_base;

    assign slice_base = int'(cnt_q) * SLICE;
    assign slice_x    = a_q[slice_base +: SLICE];
    assign slice_y    = b_q[slice_base +: SLICE];
    assign last_slice = (cnt_q == CNT_W'(NSLICE - 1));

    nibble_sub_slice #(.W(SLICE)) u_slice (
        .x    (slice_x),
        .y    (slice_y),
        .bin  (borrow_q),
        .diff (slice_diff),
        .bout (slice_bout)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        d_d      = d_q;
        bo_d     = bo_q;
`ifdef SUB_OVERFLOW_FLAG_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    borrow_d = bus.bi;
                    cnt_d    = '0;
                    d_d      = '0;
                    bo_d     = 1'b0;
`ifdef SUB_OVERFLOW_FLAG_EN
                    ovf_d    = 1'b0;
`endif
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                d_d[slice_base +: SLICE] = slice_diff;
                borrow_d = slice_bout;
                cnt_d    = cnt_q + 1'b1;
                if (last_slice) begin
                    bo_d    = slice_bout;
                    cnt_d   = '0;
                    state_d = DONE;
`ifdef SUB_OVERFLOW_FLAG_EN
                    // The last slice's MSB is the result MSB.
                    ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                            (slice_diff[SLICE-1] != a_q[WIDTH-1]);
`endif
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Registered handshake outputs keep in_ready low while reset is held.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            borrow_q    <= 1'b0;
            d_q         <= '0;
            bo_q        <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef SUB_OVERFLOW_FLAG_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            borrow_q    <= borrow_d;
            d_q         <= d_d;
            bo_q        <= bo_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef SUB_OVERFLOW_FLAG_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.d         = d_q;
    assign bus.bo        = bo_q;
    assign bus.dbg_state = state_q;
`ifdef SUB_OVERFLOW_FLAG_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor: directed cases, backpressure,
// mid-operation reset, back-to-back and random traffic against an arithmetic model.
module tb_nibble_serial_subtractor;
    import sub_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nibble_serial_subtractor_if #(.WIDTH(16)) bus ();

    nibble_serial_subtractor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [17:0] exp_q[$];   // {ovf, bo, d}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Plain integer arithmetic: unsigned difference, borrow as sign, signed range test.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic bi);
        int          ud;
        int          sd;
        logic [15:0] d;
        logic        bo;
        logic        ovf;
        ud  = int'(a) - int'(b) - int'(bi);
        bo  = (ud < 0);
        d   = 16'(ud + 65536);
        sd  = int'($signed(a)) - int'($signed(b)) - int'(bi);
        ovf = (sd < -32768) || (sd > 32767);
        return {ovf, bo, d};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.a, bus.b, bus.bi));
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    chk("sb_d", 32'(bus.d), 32'(exp_q[0][15:0]));
                    chk("sb_bo", 32'(bus.bo), 32'(exp_q[0][16]));
`ifdef SUB_OVERFLOW_FLAG_EN
                    chk("sb_ovf", 32'(bus.ovf), 32'(exp_q[0][17]));
`endif
                    chk("in_ready_in_done", 32'(bus.in_ready), 32'd0);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic bi);
        int n;
        n = 0;
        bus.a        = a;
        bus.b        = b;
        bus.bi       = bi;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = 16'($urandom);
        bus.b        = 16'($urandom);
        bus.bi       = 1'($urandom);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        @(negedge clk);
        while (!bus.out_valid && lat < 50) begin
            lat++;
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
            @(negedge clk);
        end
        if (!bus.out_valid) chk("result_timeout", 32'd0, 32'd1);
    endtask

    task automatic directed(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic bi, input logic [15:0] ed, input logic ebo);
        int lat;
        bus.out_ready = 1'b1;
        send(a, b, bi);
        wait_out(lat);
        chk({name, "_latency"}, 32'(lat), 32'd4);
        chk({name, "_d"}, 32'(bus.d), 32'(ed));
        chk({name, "_bo"}, 32'(bus.bo), 32'(ebo));
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [17:0] pin;
        logic [15:0] held_d;
        int          lat;
        int          prev;
        int          n;
        int          sent;
        int          guard;
        logic        acc;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bi        = 1'b0;
        bus.out_ready = 1'b0;

        // Model pins, computed by hand.
        pin = model(16'h0000, 16'h0001, 1'b0);
        chk("model_wrap", 32'(pin), 32'h1FFFF);
        pin = model(16'h8000, 16'h0001, 1'b0);
        chk("model_ovf", 32'(pin), 32'h27FFF);

        // Reset state.
        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_d", 32'(bus.d), 32'd0);
        chk("rst_bo", 32'(bus.bo), 32'd0);
        chk("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed arithmetic cases.
        directed("basic",  16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0);
        directed("wrap",   16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
        directed("xnib",   16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0);
        directed("eq_bi",  16'h5555, 16'h5555, 1'b1, 16'hFFFF, 1'b1);
        directed("eq",     16'hA5A5, 16'hA5A5, 1'b0, 16'h0000, 1'b0);
        directed("ovf",    16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0);
`ifdef SUB_OVERFLOW_FLAG_EN
        bus.out_ready = 1'b0;
        send(16'h8000, 16'h0001, 1'b0);
        wait_out(lat);
        chk("ovf_flag", 32'(bus.ovf), 32'd1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
`endif

        // Backpressure: result held for 10 cycles.
        bus.out_ready = 1'b0;
        send(16'h4321, 16'h1111, 1'b1);
        wait_out(lat);
        held_d = bus.d;
        chk("bp_d", 32'(held_d), 32'h320F);
        repeat (10) begin
            bus.a = 16'($urandom);
            @(negedge clk);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_d_stable", 32'(bus.d), 32'(held_d));
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", 32'(bus.in_ready), 32'd1);
        chk("release_out_valid", 32'(bus.out_valid), 32'd0);

        // Reset pulse during slice 2.
        send(16'h1234, 16'h1111, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_d", 32'(bus.d), 32'd0);
        chk("midrst_bo", 32'(bus.bo), 32'd0);
        chk("midrst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        directed("after_rst", 16'hFFFF, 16'h0F0F, 1'b0, 16'hF0F0, 1'b0);

        // Back-to-back with in_valid held high.
        bus.out_ready = 1'b1;
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            bus.a        = 16'($urandom);
            bus.b        = 16'($urandom);
            bus.bi       = 1'($urandom);
            bus.in_valid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!bus.in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (!bus.in_ready) chk("b2b_timeout", 32'd0, 32'd1);
            if (i > 0) chk("b2b_spacing", 32'(cyc - prev), 32'd6);
            prev = cyc;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;

        // Random traffic with random backpressure.
        sent  = 0;
        guard = 0;
        while ((sent < 40 || exp_q.size() > 0 || bus.in_valid) && guard < 5000) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) sent++;
            if (acc || !bus.in_valid) begin
                if (sent < 40 && $urandom_range(0, 2) != 0) begin
                    bus.in_valid = 1'b1;
                    case ($urandom_range(0, 3))
                        0:       begin bus.a = 16'h0000; bus.b = 16'($urandom); end
                        1:       begin bus.a = 16'($urandom); bus.b = 16'hFFFF; end
                        default: begin bus.a = 16'($urandom); bus.b = 16'($urandom); end
                    endcase
                    bus.bi = 1'($urandom);
                end else begin
                    bus.in_valid = 1'b0;
                    bus.a        = 16'($urandom);
                    bus.b        = 16'($urandom);
                end
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            guard++;
        end
        if (guard >= 5000) chk("random_timeout", 32'd0, 32'd1);
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("random_sent", 32'(sent), 32'd40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
